seq_bcd_disp: RTL

- Sequential binary-to-BCD converter with a seven-segment encoder for three digits.
- Sits directly downstream of the display slave's parallel data register. A one-cycle write strobe from that register starts a conversion.
- Uses an iterative shift-add-3 (double-dabble) conversion at one bit per clock, in place of a combinational converter.
- Display outputs hold the last converted value until the next conversion completes.

---
 rtl/seq_bcd_disp.sv | 83 ++++++++
 1 files changed

// File: rtl/seq_bcd_disp.sv
// seq_bcd_disp: bit-serial double-dabble binary-to-BCD converter driving three active-low seven-segment digits.
module seq_bcd_disp #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic [11:0]           bcd,
  output logic [6:0]            dout0,
  output logic [6:0]            dout1,
  output logic [6:0]            dout2
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] sh;
  logic [11:0] wb, wc;
  logic [CW-1:0] cnt;
  function automatic logic [3:0] adj(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
  assign wc = {adj(wb[11:8]), adj(wb[7:4]), adj(wb[3:0])};
  assign busy = (state == SHIFT) || (state == UPDATE);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = load ? SHIFT : IDLE;
      SHIFT:   state_nx = (cnt == CW'(1)) ? UPDATE : SHIFT;
      default: state_nx = IDLE;
    endcase
  end
  // display registers only move in UPDATE, so partial conversions are never visible
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh    <= '0;
      wb    <= '0;
      cnt   <= '0;
      bcd   <= '0;
      done  <= 1'b0;
      dout0 <= 7'b1000000;
      dout1 <= 7'b1000000;
      dout2 <= 7'b1000000;
    end else begin
      done <= state == UPDATE;
      if (state == IDLE && load) begin
        sh  <= din;
        wb  <= '0;
        cnt <= CW'(DATA_WIDTH);
      end
      if (state == SHIFT) begin
        wb  <= (wc << 1) | 12'(sh[DATA_WIDTH-1]);
        sh  <= sh << 1;
        cnt <= cnt - CW'(1);
      end
      if (state == UPDATE) begin
        bcd   <= wb;
        dout0 <= seg(wb[3:0]);
        dout1 <= seg(wb[7:4]);
        dout2 <= seg(wb[11:8]);
      end
    end
endmodule
